// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Holds the FSM state encoding, the NOP bubble and the IF/ID bundle layout.
package fetch_pkg;

  localparam int BITS   = 32;
  localparam int ADDR_W = BITS - 2;
  localparam logic [BITS-1:0] NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic            valid;
    logic [BITS-1:0] instr;
    logic [BITS-1:0] pc4;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '{valid: 1'b0, instr: NOP, pc4: '0};

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: one cycle, flush beats load, holds when neither is set.
// No backpressure of its own; the caller withholds load while decode stalls.
module if_id_reg
  import fetch_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   load,
  input  logic   flush,
  input  if_id_t d,
  output if_id_t q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= IF_ID_BUBBLE;
    end else if (flush) begin
      q <= IF_ID_BUBBLE;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC-driven imem requests into IF/ID, one-entry skid for decode stalls,
// redirect squashes IF/ID and skid; an in-flight request at redirect is drained in DROP.
module fetch_unit
  import fetch_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [BITS-1:0]   pc_in,
  output logic [ADDR_W-1:0] pc_next,
  output logic              pc_hold,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [BITS-1:0]   imem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_target,
  input  logic              id_stall,
  output logic              if_id_valid,
  output logic [BITS-1:0]   if_id_instr,
  output logic [BITS-1:0]   if_id_pc4
);

  fetch_state_t      state, state_nx;
  if_id_t            skid, skid_nx;
  if_id_t            if_id_d, if_id_q;
  logic              if_id_load, if_id_flush;
  logic [ADDR_W-1:0] drop_addr, drop_addr_nx;
  logic [ADDR_W-1:0] pc_word;
  logic [BITS-1:0]   pc4;

  assign pc_word = pc_in[BITS-1:2];
  assign pc4     = pc_in + BITS'(4);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FETCH;
      skid      <= IF_ID_BUBBLE;
      drop_addr <= '0;
    end else begin
      state     <= state_nx;
      skid      <= skid_nx;
      drop_addr <= drop_addr_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    skid_nx      = skid;
    drop_addr_nx = drop_addr;
    imem_req     = 1'b0;
    imem_addr    = pc_word;
    pc_hold      = 1'b1;
    pc_next      = pc_word + ADDR_W'(1);
    if_id_load   = 1'b0;
    if_id_flush  = 1'b0;
    if_id_d      = skid;

    unique case (state)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          pc_hold = 1'b0;
          if (id_stall) begin
            skid_nx  = '{valid: 1'b1, instr: imem_rdata, pc4: pc4};
            state_nx = HOLD;
          end else begin
            if_id_load = 1'b1;
            if_id_d    = '{valid: 1'b1, instr: imem_rdata, pc4: pc4};
          end
        end else if (!id_stall) begin
          if_id_flush = 1'b1;
        end
      end
      // PC already points past the skid entry, so nothing is requested here.
      HOLD: begin
        if (!id_stall) begin
          if_id_load = 1'b1;
          if_id_d    = skid;
          skid_nx    = IF_ID_BUBBLE;
          state_nx   = FETCH;
        end
      end
      DROP: begin
        imem_req  = 1'b1;
        imem_addr = drop_addr;
        if (imem_ack) state_nx = FETCH;
        if (!id_stall) if_id_flush = 1'b1;
      end
      default: state_nx = FETCH;
    endcase

    // Redirect overrides stall and any same-cycle response.
    if (redirect) begin
      pc_hold     = 1'b0;
      pc_next     = redirect_target;
      if_id_load  = 1'b0;
      if_id_flush = 1'b1;
      skid_nx     = IF_ID_BUBBLE;
      unique case (state)
        FETCH: begin
          if (imem_ack) begin
            state_nx = FETCH;
          end else begin
            state_nx     = DROP;
            drop_addr_nx = pc_word;
          end
        end
        HOLD:    state_nx = FETCH;
        DROP:    state_nx = DROP;
        default: state_nx = FETCH;
      endcase
    end

    if (reset) begin
      imem_req = 1'b0;
      pc_hold  = 1'b1;
    end
  end

  if_id_reg u_if_id_reg (
    .clk   (clk),
    .reset (reset),
    .load  (if_id_load),
    .flush (if_id_flush),
    .d     (if_id_d),
    .q     (if_id_q)
  );

  assign if_id_valid = if_id_q.valid;
  assign if_id_instr = if_id_q.instr;
  assign if_id_pc4   = if_id_q.pc4;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: PC register and latency-programmable memory around the DUT,
// with a program-order scoreboard checking every instruction decode accepts.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc_in = 32'h0;
  logic [29:0] pc_next;
  logic        pc_hold;
  logic        imem_req;
  logic [29:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect = 1'b0;
  logic [29:0] redirect_target = 30'h0;
  logic        id_stall = 1'b0;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;

  fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .pc_in           (pc_in),
    .pc_next         (pc_next),
    .pc_hold         (pc_hold),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .id_stall        (id_stall),
    .if_id_valid     (if_id_valid),
    .if_id_instr     (if_id_instr),
    .if_id_pc4       (if_id_pc4)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_consumed = 0;

  // Memory: cfg_lat < 0 picks a random 0..2 cycle latency per request.
  int          cfg_lat = 0;
  int          lat_left = -1;
  logic        ovr_en = 1'b0;
  logic [31:0] ovr_dat = 32'h0;

  // Transaction-level model state.
  logic        stale = 1'b0;
  logic        pend = 1'b0;
  logic [29:0] pend_addr = 30'h0;
  logic [29:0] exp_pc = 30'h0;

  // Per-cycle samples.
  logic        s_req, s_hold, s_ack;
  logic [29:0] s_addr, s_next;

  function automatic logic [31:0] memfn(input logic [29:0] a);
    return {2'b10, a} ^ 32'h5A5A_0F0F;
  endfunction

  // One clock cycle: drive inputs, serve memory, score against the program-order model,
  // then advance the PC register exactly as the real PC would.
  task automatic step(input logic stall, input logic redir, input logic [29:0] tgt,
                      input logic rst);
    logic [31:0] pc_new;
    logic        exp_hold;
    logic [29:0] exp_next;
    @(negedge clk);
    reset = rst; id_stall = stall; redirect = redir; redirect_target = tgt;
    imem_ack = 1'b0; imem_rdata = 32'h0;
    #1;
    s_req = imem_req; s_addr = imem_addr; s_ack = 1'b0;
    if (!rst && s_req) begin
      if (lat_left < 0) lat_left = (cfg_lat < 0) ? int'($urandom_range(0, 2)) : cfg_lat;
      if (lat_left == 0) begin
        s_ack = 1'b1; lat_left = -1;
      end else begin
        lat_left = lat_left - 1;
      end
    end
    imem_ack = s_ack;
    imem_rdata = s_ack ? (ovr_en ? ovr_dat : memfn(s_addr)) : 32'h0;
    #1;
    s_hold = pc_hold; s_next = pc_next;
    if (rst) begin
      n_checks++;
      if (s_req !== 1'b0 || s_hold !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_outputs: imem_req=%b pc_hold=%b, required 0 and 1", s_req, s_hold);
      end
      lat_left = -1; stale = 1'b0; pend = 1'b0; exp_pc = pc_in[31:2];
    end else begin
      if (pend) begin
        n_checks++;
        if (s_req !== 1'b1 || s_addr !== pend_addr) begin
          n_fail++;
          $display("FAIL req_stable: req=%b addr=%h, required 1 and %h", s_req, s_addr, pend_addr);
        end
      end
      if (if_id_valid === 1'b1 && !stall) begin
        n_checks++;
        if (if_id_instr !== memfn(exp_pc) || if_id_pc4 !== ({exp_pc, 2'b00} + 32'd4)) begin
          n_fail++;
          $display("FAIL in_order: instr=%h pc4=%h, required %h %h", if_id_instr, if_id_pc4,
                   memfn(exp_pc), {exp_pc, 2'b00} + 32'd4);
        end
        exp_pc = exp_pc + 30'd1;
        n_consumed++;
      end
      if (redir) exp_pc = tgt;
      exp_hold = !(redir || (s_ack && !stale));
      exp_next = redir ? tgt : pc_in[31:2] + 30'd1;
      n_checks++;
      if (s_hold !== exp_hold || (!exp_hold && s_next !== exp_next)) begin
        n_fail++;
        $display("FAIL pc_update: hold=%b next=%h, required %b %h", s_hold, s_next,
                 exp_hold, exp_next);
      end
      if (s_req) stale = s_ack ? (redir && stale) : (stale || redir);
      else       stale = 1'b0;
      pend = s_req && !s_ack;
      pend_addr = s_addr;
    end
    pc_new = s_hold ? pc_in : {s_next, 2'b00};
    @(posedge clk);
    #1;
    pc_in = pc_new;
  endtask

  task automatic restart(input logic [31:0] pc);
    pc_in = pc;
    step(1'b0, 1'b0, 30'h0, 1'b1);
  endtask

  task automatic test_reset();
    restart(32'h0);
    n_checks++;
    if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || if_id_pc4 !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_if_id: v=%b i=%h p=%h, required 0 0 0", if_id_valid, if_id_instr,
               if_id_pc4);
    end
  endtask

  task automatic test_zero_wait();
    cfg_lat = 0;
    restart(32'h0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 30'h0, 1'b0);
      n_checks++;
      if (s_hold !== 1'b0 || s_next !== 30'(i + 1)) begin
        n_fail++;
        $display("FAIL zero_wait_pc: hold=%b next=%h, required 0 %h", s_hold, s_next, i + 1);
      end
      n_checks++;
      if (if_id_valid !== 1'b1 || if_id_pc4 !== 32'(4 * (i + 1)) ||
          if_id_instr !== memfn(30'(i))) begin
        n_fail++;
        $display("FAIL zero_wait_ifid: v=%b pc4=%h, required 1 %h", if_id_valid, if_id_pc4,
                 4 * (i + 1));
      end
    end
  endtask

  task automatic test_latency();
    cfg_lat = 2;
    restart(32'h100);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 30'h0, 1'b0);
      if (i < 2) begin
        n_checks++;
        if (s_hold !== 1'b1 || s_addr !== 30'h40 || if_id_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL latency_wait: hold=%b addr=%h v=%b, required 1 40 0", s_hold, s_addr,
                   if_id_valid);
        end
      end else begin
        n_checks++;
        if (s_hold !== 1'b0 || s_next !== 30'h41 || if_id_valid !== 1'b1 ||
            if_id_pc4 !== 32'h104) begin
          n_fail++;
          $display("FAIL latency_ack: hold=%b next=%h pc4=%h, required 0 41 104", s_hold,
                   s_next, if_id_pc4);
        end
      end
    end
  endtask

  task automatic test_stall_skid();
    cfg_lat = 0;
    restart(32'h300);
    step(1'b0, 1'b0, 30'h0, 1'b0);
    step(1'b1, 1'b0, 30'h0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, 30'h0, 1'b0);
      n_checks++;
      if (s_req !== 1'b0 || if_id_pc4 !== 32'h304) begin
        n_fail++;
        $display("FAIL skid_hold: req=%b pc4=%h, required 0 304", s_req, if_id_pc4);
      end
    end
    step(1'b0, 1'b0, 30'h0, 1'b0);
    n_checks++;
    if (s_hold !== 1'b1 || s_req !== 1'b0 || if_id_pc4 !== 32'h308 ||
        if_id_instr !== memfn(30'hC1)) begin
      n_fail++;
      $display("FAIL skid_release: hold=%b req=%b pc4=%h, required 1 0 308", s_hold, s_req,
               if_id_pc4);
    end
    step(1'b0, 1'b0, 30'h0, 1'b0);
    n_checks++;
    if (s_addr !== 30'hC2 || if_id_pc4 !== 32'h30C) begin
      n_fail++;
      $display("FAIL skid_resume: addr=%h pc4=%h, required C2 30C", s_addr, if_id_pc4);
    end
  endtask

  task automatic test_redirect_drop();
    cfg_lat = 3;
    restart(32'h400);
    step(1'b0, 1'b0, 30'h0, 1'b0);
    step(1'b0, 1'b1, 30'h200, 1'b0);
    n_checks++;
    if (s_hold !== 1'b0 || s_next !== 30'h200) begin
      n_fail++;
      $display("FAIL drop_redirect: hold=%b next=%h, required 0 200", s_hold, s_next);
    end
    step(1'b0, 1'b0, 30'h0, 1'b0);
    n_checks++;
    if (s_req !== 1'b1 || s_addr !== 30'h100 || s_hold !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_state: req=%b addr=%h hold=%b, required 1 100 1", s_req, s_addr, s_hold);
    end
    ovr_en = 1'b1; ovr_dat = 32'hDEAD_BEEF;
    step(1'b0, 1'b0, 30'h0, 1'b0);
    ovr_en = 1'b0;
    n_checks++;
    if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0) begin
      n_fail++;
      $display("FAIL drop_discard: v=%b instr=%h, required 0 0", if_id_valid, if_id_instr);
    end
    cfg_lat = 0;
    step(1'b0, 1'b0, 30'h0, 1'b0);
    n_checks++;
    if (s_addr !== 30'h200 || if_id_instr !== memfn(30'h200) || if_id_pc4 !== 32'h804) begin
      n_fail++;
      $display("FAIL drop_refetch: addr=%h instr=%h pc4=%h, required 200 %h 804", s_addr,
               if_id_instr, if_id_pc4, memfn(30'h200));
    end
  endtask

  task automatic test_redirect_hold();
    cfg_lat = 0;
    restart(32'h500);
    step(1'b0, 1'b0, 30'h0, 1'b0);
    step(1'b1, 1'b0, 30'h0, 1'b0);
    step(1'b1, 1'b1, 30'h50, 1'b0);
    n_checks++;
    if (s_req !== 1'b0 || s_hold !== 1'b0 || s_next !== 30'h50 ||
        if_id_valid !== 1'b0 || if_id_instr !== 32'h0) begin
      n_fail++;
      $display("FAIL hold_redirect: req=%b hold=%b next=%h v=%b, required 0 0 50 0", s_req,
               s_hold, s_next, if_id_valid);
    end
    step(1'b0, 1'b0, 30'h0, 1'b0);
    n_checks++;
    if (s_req !== 1'b1 || s_addr !== 30'h50 || if_id_instr !== memfn(30'h50)) begin
      n_fail++;
      $display("FAIL hold_refetch: req=%b addr=%h instr=%h, required 1 50 %h", s_req, s_addr,
               if_id_instr, memfn(30'h50));
    end
  endtask

  task automatic test_wrap_reset();
    cfg_lat = 0;
    restart(32'hFFFF_FFFC);
    step(1'b0, 1'b0, 30'h0, 1'b0);
    n_checks++;
    if (s_hold !== 1'b0 || s_next !== 30'h0 || if_id_pc4 !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap: hold=%b next=%h pc4=%h, required 0 0 0", s_hold, s_next, if_id_pc4);
    end
    cfg_lat = 3;
    step(1'b0, 1'b0, 30'h0, 1'b0);
    step(1'b0, 1'b1, 30'h10, 1'b0);
    step(1'b0, 1'b0, 30'h0, 1'b1);
    n_checks++;
    if (if_id_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_in_drop: v=%b, required 0", if_id_valid);
    end
    cfg_lat = 0;
    step(1'b0, 1'b0, 30'h0, 1'b0);
    n_checks++;
    if (s_req !== 1'b1 || s_addr !== 30'h10) begin
      n_fail++;
      $display("FAIL reset_to_fetch: req=%b addr=%h, required 1 10", s_req, s_addr);
    end
  endtask

  task automatic test_random();
    int          start_cnt;
    logic        st, rd, rs;
    logic [29:0] tg;
    cfg_lat = -1;
    restart({22'h0, 8'($urandom_range(0, 255)), 2'b00});
    start_cnt = n_consumed;
    for (int i = 0; i < 1500; i++) begin
      st = ($urandom_range(0, 99) < 30);
      rs = ($urandom_range(0, 199) == 0);
      rd = !rs && ($urandom_range(0, 99) < 6);
      tg = ($urandom_range(0, 3) == 0) ? 30'h3FFF_FFF0 + 30'($urandom_range(0, 15))
                                       : 30'($urandom_range(0, 1023));
      step(st, rd, tg, rs);
    end
    n_checks++;
    if (n_consumed - start_cnt < 150) begin
      n_fail++;
      $display("FAIL random_progress: consumed %0d, required at least 150", n_consumed - start_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_latency();
    test_stall_skid();
    test_redirect_drop();
    test_redirect_hold();
    test_wrap_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage of the pipelined MIPS core. It sits between the program counter register and the IF/ID boundary.
- Consumes the PC's byte address and drives the PC's next word address and hold input.
- Issues requests to instruction memory and fills the IF/ID register.
- Handles decode stalls through a one-entry skid buffer, and handles branch/jump redirects, including discarding in-flight responses.

Parameters:
BITS, 32, datapath and byte-address width
ADDR_W, BITS-2, word-address width (PC holds word address)
NOP, 32'h0000_0000, instruction injected on flush/reset

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high reset
pc_in  in  BITS  current PC byte address (low 2 bits always 0)
pc_next  out  ADDR_W  next PC word address to PC register
pc_hold  out  1  1 = PC keeps current value (drives PC hold/write-inhibit input)
imem_req  out  1  instruction-memory request
imem_addr  out  ADDR_W  word address of request
imem_ack  in  1  1-cycle pulse, imem_rdata valid same cycle
imem_rdata  in  BITS  fetched instruction
redirect  in  1  taken branch/jump from later stage
redirect_target  in  ADDR_W  word address of redirect
id_stall  in  1  decode cannot accept; IF/ID must hold
if_id_valid  out  1  IF/ID holds a real instruction
if_id_instr  out  BITS  IF/ID instruction
if_id_pc4  out  BITS  byte address of instruction + 4

Behaviour:
- Clock and reset: one clock (clk); reset synchronous, active-high.
- States: FETCH, HOLD, DROP. Reset value: FETCH.
- Reset values:
  - if_id_valid=0, if_id_instr=NOP, if_id_pc4=0; skid empty.
  - While reset=1: imem_req=0, pc_hold=1.
- Request protocol: imem_req and imem_addr are stable from assertion until the cycle imem_ack=1. Zero-wait ack (same cycle as req) is legal.
- FETCH:
  - imem_req=1, imem_addr=pc_in[BITS-1:2].
  - No ack: pc_hold=1.
  - Ack: pc_hold=0, pc_next=pc_in[BITS-1:2]+1, mod 2^ADDR_W (wraps 3FFF_FFFF->0).
  - Ack with id_stall=0: IF/ID <= {1, rdata, pc_in+4}.
  - Ack with id_stall=1: skid <= {rdata, pc_in+4}, go HOLD.
  - No ack with id_stall=0: IF/ID <= bubble (valid=0, NOP).
- HOLD:
  - imem_req=0, pc_hold=1. The PC has already advanced past the skid instruction.
  - When id_stall=0: IF/ID <= skid, skid emptied, go FETCH.
- DROP:
  - imem_req=1, imem_addr=drop_addr (captured at redirect). pc_hold=1.
  - On ack: response discarded, go FETCH.
  - IF/ID loads bubbles when id_stall=0.
- Redirect (highest priority, overrides id_stall):
  - pc_hold=0, pc_next=redirect_target.
  - IF/ID <= bubble; skid emptied.
  - Next state:
    - FETCH with request pending and no ack this cycle: DROP, drop_addr <= pc_in[BITS-1:2].
    - FETCH with ack this cycle: response discarded, stay FETCH.
    - HOLD: go FETCH.
    - DROP: stay DROP; drop_addr unchanged.
- Simultaneous ack and id_stall while IF/ID is empty: still goes to skid. IF/ID holds whenever id_stall=1.
- Invariant: PC advances exactly once per accepted (non-discarded) response or redirect. No instruction is duplicated or lost.
- Reset mid-operation (any state, pending request): back to FETCH. imem_req drops the same cycle; memory must tolerate abandoned requests on reset.
- pc_next is always driven; it is only meaningful when pc_hold=0.

Decomposition:
- Package fetch_pkg: state enum (FETCH/HOLD/DROP), NOP constant, ADDR_W, and the IF/ID bundle typedef {valid, instr, pc4}.
- One sub-module: if_id_reg, the IF/ID pipeline register with load/hold/flush controls.
- The FSM, skid buffer and next-PC mux stay in fetch_unit.

Test Plan:
- Zero-wait memory, pc_in=0x0: over 4 cycles, 4 instructions enter IF/ID with pc4=0x4,0x8,0xC,0x10; pc_hold=0 each cycle; pc_next=1,2,3,4.
- Ack latency 2, pc_in=0x100: pc_hold=1 and imem_addr=0x40 for 2 cycles; on ack pc_next=0x41; IF/ID gets bubbles, then the instruction with pc4=0x104.
- Ack with id_stall=1 for 3 cycles: state=HOLD, imem_req=0, IF/ID unchanged; after release IF/ID=skid instruction, pc_hold=1 that cycle, then fetching resumes.
- Redirect to 0x200 while a request is pending without ack: next state DROP, pc_next=0x200. The returning response 0xDEADBEEF never reaches IF/ID. The next fetch has imem_addr=0x200.
- Redirect with id_stall=1 in HOLD: IF/ID flushed (valid=0, NOP), skid emptied, state FETCH.
- pc_in=0xFFFF_FFFC with ack: pc_next=0 (wrap). Reset asserted in DROP: next cycle FETCH, imem_req=0, if_id_valid=0.
